// File: rtl/matriz_carregador.sv
// matriz_carregador: stream-to-matrix loader.
// Collects row-major elements, one per valid/ready transfer, into a
// packed MAX_N x MAX_N bus. The completed matrix is presented with a
// valid/ready handshake. Positions beyond N*N are always zero.
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   start, tam           begin a load of size N = tam+2 (sampled in IDLE)
//   clear                synchronous abort back to IDLE, wins over everything
//   in_valid/in_data     element stream input, in_ready back-pressure
//   matriz_A/out_valid   packed matrix output, element k at [k*DATA_W +: DATA_W]
//   out_ready            consumer accepts matriz_A
//   busy, tam_out        loader active (LOAD or HOLD), size code held
module matriz_carregador #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MAX_N  = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [1:0]                      tam,
  input  logic                            clear,
  input  logic                            in_valid,
  input  logic [DATA_W-1:0]               in_data,
  output logic                            in_ready,
  output logic [MAX_N*MAX_N*DATA_W-1:0]   matriz_A,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy,
  output logic [1:0]                      tam_out
);

  localparam int unsigned TOTAL = MAX_N * MAX_N;
  localparam int unsigned CNT_W = $clog2(TOTAL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                              state_q;
  logic [TOTAL-1:0][DATA_W-1:0]        buf_q;
  logic [CNT_W-1:0]                    cnt_q;
  logic [1:0]                          tam_q;
  logic                                in_ready_q;
  logic                                out_valid_q;
  logic                                busy_q;
  logic [CNT_W-1:0]                    last_idx;

  // Index of the final element, N*N-1 for N = tam+2.
  always_comb begin
    last_idx = CNT_W'(3);
    unique case (tam_q)
      2'd0: last_idx = CNT_W'(3);
      2'd1: last_idx = CNT_W'(8);
      2'd2: last_idx = CNT_W'(15);
      2'd3: last_idx = CNT_W'(24);
      default: last_idx = CNT_W'(3);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      cnt_q       <= '0;
      tam_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (clear) begin
      // Abort outranks start, element transfer and out_ready; tam_out is kept.
      state_q     <= IDLE;
      buf_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= LOAD;
            tam_q      <= tam;
            buf_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        LOAD: begin
          // in_ready is always high here, so in_valid alone marks a transfer.
          if (in_valid) begin
            buf_q[cnt_q] <= in_data;
            if (cnt_q == last_idx) begin
              // Counter parks on the last index instead of stepping past it.
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign matriz_A  = buf_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign tam_out   = tam_q;

endmodule
